// File: rtl/multi_nch_disp.sv
// multi_nch_disp: shows one of NCH display channels (ch0 from EN-captured hold registers) on registered outputs.
// Latency: outputs follow the current channel by one clk; auto-scan steps every SCAN_DIV clks.
// Optional feature macro MULTI_NCH_SKIP_EN: adds ch_mask so auto-scan skips channels whose mask bit is clear.
module multi_nch_disp #(
  parameter int NCH = 8,
  parameter int DW = 32,
  parameter int PW = 8,
  parameter int SCAN_DIV = 50000,
  parameter logic [DW-1:0] INIT_DATA = 32'hAA5555AA
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     EN,
  input  logic                     auto,
  input  logic [$clog2(NCH)-1:0]   sel,
  input  logic [NCH*DW-1:0]        data_in,
  input  logic [NCH*PW-1:0]        point_in,
  input  logic [NCH*PW-1:0]        le_in,
`ifdef MULTI_NCH_SKIP_EN
  input  logic [NCH-1:0]           ch_mask,
`endif
  output logic [DW-1:0]            disp_num,
  output logic [PW-1:0]            point_out,
  output logic [PW-1:0]            le_out,
  output logic [$clog2(NCH)-1:0]   ch_out,
  output logic                     scan_tick
);

  localparam int CW = $clog2(NCH);
  localparam int DVW = $clog2(SCAN_DIV);
  localparam logic [DVW-1:0] DIV_LAST = DVW'(SCAN_DIV - 1);

  logic [DW-1:0]  hold_data;
  logic [PW-1:0]  hold_le;
  logic [PW-1:0]  hold_pt;
  logic [CW-1:0]  cur;
  logic [DVW-1:0] div;
  logic [CW-1:0]  man_ch;
  logic [CW-1:0]  nxt_ch;
  logic [DW-1:0]  mux_data;
  logic [PW-1:0]  mux_pt;
  logic [PW-1:0]  mux_le;

  // Manual select, with out-of-range values folded onto channel 0
  always_comb begin
    man_ch = sel;
    if (32'(sel) >= NCH) man_ch = '0;
  end

`ifdef MULTI_NCH_SKIP_EN
  int best;
  int dist;

  // Nearest channel after cur (wrapping, cur itself last) whose mask bit is set; 0 if none
  always_comb begin
    nxt_ch = '0;
    best = NCH + 1;
    dist = 0;
    for (int j = 0; j < NCH; j++) begin
      dist = j - int'(cur);
      if (dist <= 0) dist = dist + NCH;
      if (ch_mask[j] && (dist < best)) begin
        best = dist;
        nxt_ch = CW'(j);
      end
    end
  end
`else
  // Plain round-robin successor of cur
  always_comb begin
    nxt_ch = cur + CW'(1);
    if (cur == CW'(NCH - 1)) nxt_ch = '0;
  end
`endif

  // Channel mux: ch0 comes from the hold registers, the rest straight from the inputs
  always_comb begin
    mux_data = hold_data;
    mux_pt = hold_pt;
    mux_le = hold_le;
    for (int k = 1; k < NCH; k++) begin
      if (cur == CW'(k)) begin
        mux_data = data_in[k*DW +: DW];
        mux_pt = point_in[k*PW +: PW];
        mux_le = le_in[k*PW +: PW];
      end
    end
  end

  // Channel-0 hold registers, captured on EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_data <= INIT_DATA;
      hold_le <= '1;
      hold_pt <= '0;
    end else if (EN) begin
      hold_data <= data_in[DW-1:0];
      hold_le <= le_in[PW-1:0];
      hold_pt <= point_in[PW-1:0];
    end
  end

  // Current channel and scan divider; manual mode parks the divider at 0 so auto restarts cleanly
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur <= '0;
      div <= '0;
      scan_tick <= 1'b0;
    end else if (!auto) begin
      cur <= man_ch;
      div <= '0;
      scan_tick <= 1'b0;
    end else begin
      if (div == DIV_LAST) begin
        div <= '0;
        scan_tick <= 1'b1;
        cur <= nxt_ch;
      end else begin
        div <= div + 1'b1;
        scan_tick <= 1'b0;
      end
`ifdef MULTI_NCH_SKIP_EN
      if (ch_mask == '0) cur <= '0;
`endif
    end
  end

  // Registered display outputs for the channel that was current at this edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      disp_num <= INIT_DATA;
      le_out <= '1;
      point_out <= '0;
      ch_out <= '0;
    end else begin
      disp_num <= mux_data;
      le_out <= mux_le;
      point_out <= mux_pt;
      ch_out <= cur;
    end
  end

endmodule

// File: tb/tb_multi_nch_disp.sv
// tb_multi_nch_disp: directed plus randomized stimulus against a cycle-level reference model.
// Model tracks current channel, cycles since last scan step and channel-0 hold values.
// Every step compares all five outputs; directed steps add explicit value checks.
module tb_multi_nch_disp;

  localparam int NCH = 8;
  localparam int SD = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         auto_s;
  logic [2:0]   sel;
  logic [255:0] data_in;
  logic [63:0]  point_in;
  logic [63:0]  le_in;
`ifdef MULTI_NCH_SKIP_EN
  logic [7:0]   ch_mask;
`endif
  logic [31:0]  disp_num;
  logic [7:0]   point_out;
  logic [7:0]   le_out;
  logic [2:0]   ch_out;
  logic         scan_tick;

  multi_nch_disp #(.NCH(NCH), .DW(32), .PW(8), .SCAN_DIV(SD), .INIT_DATA(32'hAA5555AA)) dut (
    .clk(clk), .rst(rst), .EN(en), .auto(auto_s), .sel(sel),
    .data_in(data_in), .point_in(point_in), .le_in(le_in),
`ifdef MULTI_NCH_SKIP_EN
    .ch_mask(ch_mask),
`endif
    .disp_num(disp_num), .point_out(point_out), .le_out(le_out),
    .ch_out(ch_out), .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int checks = 0;
  int miscompares = 0;

  // reference model state
  int          m_cur;
  int          m_cnt;
  logic [31:0] m_hd;
  logic [7:0]  m_hle;
  logic [7:0]  m_hpt;
  logic [31:0] e_disp;
  logic [7:0]  e_pt;
  logic [7:0]  e_le;
  int          e_ch;
  logic        e_tick;

  int seen[$];
  int ticks;

  function automatic logic [7:0] cur_mask();
`ifdef MULTI_NCH_SKIP_EN
    return ch_mask;
`else
    return 8'hFF;
`endif
  endfunction

  function automatic int next_ch(int c, logic [7:0] mk);
    for (int k = 1; k <= NCH; k++)
      if (mk[(c + k) % NCH]) return (c + k) % NCH;
    return 0;
  endfunction

  task automatic model_edge();
    logic [7:0] mk;
    mk = cur_mask();
    if (!rst) begin
      m_hd = 32'hAA5555AA; m_hle = 8'hFF; m_hpt = 8'h00;
      m_cur = 0; m_cnt = 0;
      e_disp = 32'hAA5555AA; e_le = 8'hFF; e_pt = 8'h00; e_ch = 0; e_tick = 1'b0;
    end else begin
      e_ch = m_cur;
      if (m_cur == 0) begin
        e_disp = m_hd; e_le = m_hle; e_pt = m_hpt;
      end else begin
        e_disp = data_in[m_cur*32 +: 32];
        e_le = le_in[m_cur*8 +: 8];
        e_pt = point_in[m_cur*8 +: 8];
      end
      if (en) begin
        m_hd = data_in[31:0]; m_hle = le_in[7:0]; m_hpt = point_in[7:0];
      end
      e_tick = 1'b0;
      if (!auto_s) begin
        m_cur = (int'(sel) < NCH) ? int'(sel) : 0;
        m_cnt = 0;
      end else begin
        m_cnt = m_cnt + 1;
        if (m_cnt == SD) begin
          m_cnt = 0;
          e_tick = 1'b1;
          m_cur = next_ch(m_cur, mk);
        end
        if (mk == 8'h00) m_cur = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    vectors++;
    chk("disp_num", disp_num, e_disp);
    chk("point_out", {24'h0, point_out}, {24'h0, e_pt});
    chk("le_out", {24'h0, le_out}, {24'h0, e_le});
    chk("ch_out", {29'h0, ch_out}, 32'(e_ch));
    chk("scan_tick", {31'h0, scan_tick}, {31'h0, e_tick});
  endtask

  // run n steps, recording ch_out on the step after each tick
  task automatic run_collect(input int n);
    logic prev;
    prev = 1'b0;
    seen.delete();
    ticks = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (prev) seen.push_back(int'(ch_out));
      prev = scan_tick;
      if (scan_tick) ticks++;
    end
  endtask

  initial begin
    int n;
    rst = 1'b0; en = 1'b0; auto_s = 1'b0; sel = 3'd0;
    data_in = '0; point_in = '0; le_in = '0;
    for (int k = 0; k < NCH; k++) begin
      data_in[k*32 +: 32] = $urandom;
      point_in[k*8 +: 8] = 8'($urandom);
      le_in[k*8 +: 8] = 8'($urandom);
    end
`ifdef MULTI_NCH_SKIP_EN
    ch_mask = 8'hFF;
`endif

    // reset and idle defaults
    step(); step();
    chk("rst_disp", disp_num, 32'hAA5555AA);
    chk("rst_tick", {31'h0, scan_tick}, 32'h0);
    #1 rst = 1'b1;
    step();
    chk("idle_disp", disp_num, 32'hAA5555AA);
    chk("idle_le", {24'h0, le_out}, 32'hFF);
    chk("idle_pt", {24'h0, point_out}, 32'h00);
    chk("idle_ch", {29'h0, ch_out}, 32'h0);

    // channel-0 capture and hold
    data_in[31:0] = 32'h12345678; en = 1'b1;
    step();
    en = 1'b0;
    step();
    chk("hold_load", disp_num, 32'h12345678);
    data_in[31:0] = 32'h0;
    step(); step();
    chk("hold_keep", disp_num, 32'h12345678);

    // manual select
    sel = 3'd3; data_in[3*32 +: 32] = 32'hDEADBEEF; le_in[3*8 +: 8] = 8'h0F;
    step(); step();
    chk("man3_disp", disp_num, 32'hDEADBEEF);
    chk("man3_le", {24'h0, le_out}, 32'h0F);
    sel = 3'd7;
    step(); step();
    chk("man7_ch", {29'h0, ch_out}, 32'd7);
    sel = 3'd0;
    step(); step();
    chk("man0_ch", {29'h0, ch_out}, 32'd0);

    // auto scan from channel 6
    sel = 3'd6;
    step(); step();
    auto_s = 1'b1;
    run_collect(13);
    chk("auto_ticks", 32'(ticks), 32'd3);
    chk("auto_nseen", 32'(seen.size()), 32'd3);
    if (seen.size() == 3) begin
      chk("auto_seq0", 32'(seen[0]), 32'd7);
      chk("auto_seq1", 32'(seen[1]), 32'd0);
      chk("auto_seq2", 32'(seen[2]), 32'd1);
    end
    auto_s = 1'b0; sel = 3'd2;
    step(); step();
    chk("auto_off_ch", {29'h0, ch_out}, 32'd2);
    chk("auto_off_tick", {31'h0, scan_tick}, 32'h0);

    // reset mid-scan
    sel = 3'd5;
    step(); step();
    auto_s = 1'b1;
    step(); step();
    rst = 1'b0;
    step(); step();
    chk("midrst_ch", {29'h0, ch_out}, 32'd0);
    chk("midrst_tick", {31'h0, scan_tick}, 32'h0);
    rst = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!scan_tick && n < 20);
    chk("first_tick_after_rst", 32'(n), 32'(SD));

`ifdef MULTI_NCH_SKIP_EN
    // masked scan
    auto_s = 1'b0; sel = 3'd0;
    step(); step();
    ch_mask = 8'b1010_0010; auto_s = 1'b1;
    run_collect(17);
    chk("mask_nseen", 32'(seen.size()), 32'd4);
    if (seen.size() == 4) begin
      chk("mask_seq0", 32'(seen[0]), 32'd1);
      chk("mask_seq1", 32'(seen[1]), 32'd5);
      chk("mask_seq2", 32'(seen[2]), 32'd7);
      chk("mask_seq3", 32'(seen[3]), 32'd1);
    end
    ch_mask = 8'h00;
    step(); step();
    chk("mask_zero_ch", {29'h0, ch_out}, 32'd0);
    ch_mask = 8'hFF;
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) auto_s = ~auto_s;
      sel = 3'($urandom);
      en = ($urandom_range(3) == 0);
      rst = ($urandom_range(49) != 0);
      if ($urandom_range(1) == 0) begin
        int c;
        c = $urandom_range(NCH - 1);
        data_in[c*32 +: 32] = $urandom;
        point_in[c*8 +: 8] = 8'($urandom);
        le_in[c*8 +: 8] = 8'($urandom);
      end
`ifdef MULTI_NCH_SKIP_EN
      if ($urandom_range(15) == 0) ch_mask = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
`endif
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
